// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx write port between NREQ byte producers.
// Define UART_ARB_PKT_LOCK_EN to keep the port with one owner until i_req_last (or LOCK_TMO idle cycles).
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int DLEN     = 8,
  parameter int LOCK_TMO = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*DLEN-1:0] i_req_data,
  input  logic [NREQ-1:0]      i_req_last,
  output logic                 o_wvalid,
  input  logic                 i_wready,
  output logic [DLEN-1:0]      o_wdata,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef UART_ARB_PKT_LOCK_EN
  localparam int CW = $clog2(LOCK_TMO);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_LOCK} state_t;
  logic [CW-1:0] r_cnt;
  logic          r_hold_last;
  logic          w_sel_last;
  logic          w_own_valid;
`else
  typedef enum logic {S_IDLE, S_SEND} state_t;
  logic w_unused_last;
  assign w_unused_last = ^i_req_last;
`endif

  state_t          r_state, w_nstate;
  logic [PW-1:0]   r_ptr, r_grant;
  logic [DLEN-1:0] r_hold_data;
  logic [PW-1:0]   w_win, w_load_idx;
  logic [DLEN-1:0] w_sel_data;
  logic            w_found, w_load, w_done, w_gnt_en;

  // Two passes: indices above ptr first, then wrap to 0..ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int j = 0; j < NREQ; j++)
      if (!w_found && i_req_valid[j] && (PW'(j) > r_ptr)) begin
        w_found = 1'b1;
        w_win   = PW'(j);
      end
    for (int j = 0; j < NREQ; j++)
      if (!w_found && i_req_valid[j] && (PW'(j) <= r_ptr)) begin
        w_found = 1'b1;
        w_win   = PW'(j);
      end
  end

  always_comb begin
    w_nstate   = r_state;
    w_load     = 1'b0;
    w_load_idx = r_grant;
    w_done     = 1'b0;
    w_gnt_en   = 1'b0;
    o_wvalid   = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
    w_own_valid = 1'b0;
    for (int j = 0; j < NREQ; j++)
      if (PW'(j) == r_grant) w_own_valid = i_req_valid[j];
`endif
    // Reset masks accepts so nothing is taken while rstn is low.
    if (rstn) begin
      case (r_state)
        S_IDLE: if (w_found) begin
          w_load     = 1'b1;
          w_load_idx = w_win;
          w_nstate   = S_SEND;
        end
        S_SEND: begin
          o_wvalid = 1'b1;
          w_gnt_en = 1'b1;
          if (i_wready) begin
            w_done   = 1'b1;
            w_nstate = S_IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
            if (!r_hold_last) w_nstate = S_LOCK;
`endif
          end
        end
`ifdef UART_ARB_PKT_LOCK_EN
        S_LOCK: begin
          w_gnt_en = 1'b1;
          if (w_own_valid) begin
            w_load   = 1'b1;
            w_nstate = S_SEND;
          end else if (r_cnt == CW'(LOCK_TMO - 1)) begin
            w_nstate = S_IDLE;
          end
        end
`endif
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_grant     = '0;
    w_sel_data  = '0;
`ifdef UART_ARB_PKT_LOCK_EN
    w_sel_last  = 1'b0;
`endif
    for (int j = 0; j < NREQ; j++) begin
      o_req_ready[j] = w_load && (PW'(j) == w_load_idx);
      o_grant[j]     = w_gnt_en && (PW'(j) == r_grant);
      if (PW'(j) == w_load_idx) begin
        w_sel_data = i_req_data[j*DLEN +: DLEN];
`ifdef UART_ARB_PKT_LOCK_EN
        w_sel_last = i_req_last[j];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_ptr       <= PW'(NREQ - 1);
      r_grant     <= '0;
      r_hold_data <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
      r_hold_last <= 1'b1;
      r_cnt       <= '0;
`endif
    end else begin
      r_state <= w_nstate;
      if (w_load) begin
        r_hold_data <= w_sel_data;
        r_grant     <= w_load_idx;
`ifdef UART_ARB_PKT_LOCK_EN
        r_hold_last <= w_sel_last;
`endif
      end
      if (w_done) r_ptr <= r_grant;
`ifdef UART_ARB_PKT_LOCK_EN
      if (r_state == S_LOCK && w_nstate == S_LOCK) r_cnt <= r_cnt + 1'b1;
      else                                         r_cnt <= '0;
`endif
    end
  end

  assign o_wdata = r_hold_data;
  assign o_busy  = (r_state != S_IDLE);
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx write port (valid/ready/data) between NREQ byte-stream requesters. It grants one byte at a time, holds the byte in an output register until the transmitter accepts it, then re-arbitrates. It sits between on-chip byte producers (console, debug, status) and the single uart_tx instance.

Parameters:
NREQ, 4, number of requesters (2..16)
DLEN, 8, data word width; matches uart_tx DLEN
LOCK_TMO, 1024, cycles a locked requester may idle before the lock is dropped (used only with UART_ARB_PKT_LOCK_EN; minimum 2)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
i_req_valid  input  NREQ  per-requester byte valid
o_req_ready  output  NREQ  per-requester accept strobe
i_req_data  input  NREQ*DLEN  requester r data at bits [r*DLEN +: DLEN]
i_req_last  input  NREQ  end-of-packet marker per byte (ignored without UART_ARB_PKT_LOCK_EN)
o_wvalid  output  1  to uart_tx i_wvalid
i_wready  input  1  from uart_tx o_wready
o_wdata  output  DLEN  to uart_tx i_wdata
o_grant  output  NREQ  one-hot current owner, 0 when idle
o_busy  output  1  state != IDLE

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk. Reset takes priority over all activity, including a transfer in progress. Outputs after reset: o_wvalid=0, o_req_ready=0, o_grant=0, o_busy=0, o_wdata=0. Round-robin pointer ptr=NREQ-1, so requester 0 has first priority. The in-flight byte is dropped.
- ptr records the index of the last requester whose byte completed on the uart side.
- Winner is the first asserted i_req_valid, searching ptr+1, ptr+2, ... with mod-NREQ wrap.
- States: IDLE, SEND, LOCK. LOCK exists only with the macro.
- IDLE:
  - o_wvalid=0.
  - If any valid: o_req_ready[winner]=1 in the same cycle. This is combinational from i_req_valid, and only one bit is ever set.
  - Capture data into hold_data, capture last into hold_last, register grant=winner, go to SEND.
  - With no valid, stay in IDLE.
- SEND:
  - o_wvalid=1, o_wdata=hold_data, o_grant=onehot(grant). All o_req_ready=0.
  - o_wvalid and o_wdata stay constant until i_wready=1.
  - On o_wvalid&&i_wready: ptr<=grant. Next state is LOCK if lock is enabled and hold_last==0; otherwise IDLE.
- LOCK:
  - o_wvalid=0, o_grant keeps its value.
  - Only the owner can be accepted: o_req_ready[grant]=i_req_valid[grant]. Capture data, go to SEND, clear the idle counter.
  - The idle counter counts LOCK cycles with no owner valid. When it reaches LOCK_TMO-1, go to IDLE; normal round-robin from ptr resumes.
  - Other requesters are never accepted while in LOCK.
- Latency: requester accept in cycle N gives o_wvalid=1 in cycle N+1. The minimum spacing between bytes on the uart side is 2 cycles. There is no bypass, so a requester accept and a uart handshake never occur in the same cycle.
- A requester that drops valid before it is accepted loses nothing, because no accept occurred.
- Duplicate accepts are impossible: ready pulses for exactly one cycle per byte.
- NREQ=1: the arbiter degenerates to a pass-through register stage with the same timing.
- Counter width: $clog2(LOCK_TMO). Pointer and grant width: $clog2(NREQ), minimum 1.

Optional Feature:
Macro UART_ARB_PKT_LOCK_EN.
- Defined:
  - i_req_last is honoured. After a byte with last=0 completes, the owner keeps the port (LOCK state) until it sends a byte with last=1, or until it idles for LOCK_TMO cycles.
  - Packets from different requesters never interleave.
- Undefined:
  - The LOCK state and idle counter are not built, and i_req_last is unused.
  - Every completed byte returns to IDLE, giving byte-level round-robin.

Test Plan:
1. rstn=0 for 2 cycles with all i_req_valid=1 -> o_wvalid=0, o_req_ready=0, o_grant=0, o_busy=0 throughout reset. First accept after reset is requester 0.
2. Only req1 valid with data 0xA5, i_wready=1 -> o_req_ready=4'b0010 for one cycle. Next cycle o_wvalid=1, o_wdata=0xA5, o_grant=4'b0010. Handshake completes, then o_busy=0.
3. All four requesters valid continuously with data 0x10+r, i_wready=1, no macro -> uart bytes arrive in order 0x10, 0x11, 0x12, 0x13, 0x10 (wrap).
4. req3 byte 0x5A in SEND with i_wready=0 for 10 cycles -> o_wvalid=1 and o_wdata=0x5A stable, all o_req_ready=0. The single handshake on the 11th cycle is followed by IDLE.
5. Macro defined:
   - req2 sends 0x01, 0x02, 0x03 with last on 0x03 while req0 is valid throughout -> uart order 0x01, 0x02, 0x03, then req0's byte.
   - Repeat with req2 stalling after 0x02 and LOCK_TMO=16 -> after 16 LOCK cycles the lock is released and req0 is granted next.
6. rstn pulsed low during SEND with i_wready=0 -> next cycle o_wvalid=0, o_grant=0. The dropped byte is never presented to the uart, and arbitration restarts at requester 0.
